// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - 8-entry note-table square-wave tone sequencer
// Looping at sequence end is compiled in only when SOUNDGEN_LOOP_EN is defined.
module tone_sequencer #(
  parameter int BW       = 8,
  parameter int DUR_BW   = 8,
  parameter int TICK_DIV = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [2:0]        len_m1_i,
  input  logic              loop_i,
  input  logic              wr_en_i,
  input  logic [2:0]        wr_addr_i,
  input  logic [BW-1:0]     wr_period_i,
  input  logic [DUR_BW-1:0] wr_dur_i,
  output logic              tone_o,
  output logic              busy_o,
  output logic [2:0]        note_idx_o,
  output logic              done_o
);

`ifdef SOUNDGEN_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

  state_t            r_state;
  logic [2:0]        r_len;
  logic [2:0]        r_idx;
  logic [BW-1:0]     r_per;
  logic [DUR_BW-1:0] r_dur;
  logic [BW-1:0]     r_hcnt;
  logic [PW-1:0]     r_presc;
  logic              r_tone;
  logic              r_busy;
  logic              r_done;
  logic [BW-1:0]     r_tbl_per [8];
  logic [DUR_BW-1:0] r_tbl_dur [8];

  logic w_tick;
  logic w_note_end;
  logic w_last;

  assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
  assign w_note_end = w_tick && (r_dur == DUR_BW'(1));
  assign w_last     = (r_idx == r_len);

  assign tone_o     = r_tone;
  assign busy_o     = r_busy;
  assign note_idx_o = r_idx;
  assign done_o     = r_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) begin
        r_tbl_per[i] <= '0;
        r_tbl_dur[i] <= '0;
      end
    end else if (wr_en_i) begin
      r_tbl_per[wr_addr_i] <= wr_period_i;
      r_tbl_dur[wr_addr_i] <= wr_dur_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_per   <= '0;
      r_dur   <= '0;
      r_hcnt  <= '0;
      r_presc <= '0;
      r_tone  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop_i) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_idx   <= '0;
        r_tone  <= 1'b0;
        r_hcnt  <= '0;
        r_presc <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
              r_len   <= len_m1_i;
              r_idx   <= '0;
            end
          end
          S_LOAD: begin
            r_per   <= r_tbl_per[r_idx];
            r_dur   <= (r_tbl_dur[r_idx] == '0) ? DUR_BW'(1) : r_tbl_dur[r_idx];
            r_hcnt  <= '0;
            r_presc <= '0;
            r_tone  <= 1'b0;
            r_state <= S_PLAY;
          end
          S_PLAY: begin
            // A zero period is a rest: the tone stays low for the whole note.
            if (r_per != '0) begin
              if (r_hcnt == r_per - 1'b1) begin
                r_hcnt <= '0;
                r_tone <= ~r_tone;
              end else begin
                r_hcnt <= r_hcnt + 1'b1;
              end
            end
            if (w_tick) begin
              r_presc <= '0;
              r_dur   <= r_dur - 1'b1;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
            if (w_note_end) begin
              r_tone <= 1'b0;
              r_hcnt <= '0;
              if (!w_last) begin
                r_idx   <= r_idx + 3'd1;
                r_state <= S_LOAD;
              end else if (LOOP_EN && loop_i) begin
                r_idx   <= '0;
                r_state <= S_LOAD;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - self-checking bench for tone_sequencer (TICK_DIV=4)
// Honours SOUNDGEN_LOOP_EN to select looping or non-looping expectations.
module tb_tone_sequencer;
  localparam int BW     = 8;
  localparam int DUR_BW = 8;
  localparam int TD     = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic              stop_i = 1'b0;
  logic [2:0]        len_m1_i = '0;
  logic              loop_i = 1'b0;
  logic              wr_en_i = 1'b0;
  logic [2:0]        wr_addr_i = '0;
  logic [BW-1:0]     wr_period_i = '0;
  logic [DUR_BW-1:0] wr_dur_i = '0;
  logic              tone_o;
  logic              busy_o;
  logic [2:0]        note_idx_o;
  logic              done_o;

  tone_sequencer #(.BW(BW), .DUR_BW(DUR_BW), .TICK_DIV(TD)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .len_m1_i(len_m1_i), .loop_i(loop_i), .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i), .wr_period_i(wr_period_i), .wr_dur_i(wr_dur_i),
    .tone_o(tone_o), .busy_o(busy_o), .note_idx_o(note_idx_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_period [8];
  int m_dur    [8];

  // Expected per-cycle outputs; idx < 0 means the index is not specified.
  typedef struct {
    bit busy;
    int idx;
    bit tone;
    bit done;
  } exp_t;
  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int p, input int d);
    @(posedge clk); #1;
    wr_en_i = 1'b1; wr_addr_i = 3'(a); wr_period_i = BW'(p); wr_dur_i = DUR_BW'(d);
    @(posedge clk); #1;
    wr_en_i = 1'b0;
    m_period[a] = p;
    m_dur[a]    = d;
  endtask

  task automatic start_play();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  // One LOAD cycle, then max(dur,1)*TD play cycles of a clk/(2P) square wave.
  function automatic void push_note(input int i);
    int p = m_period[i];
    int d = (m_dur[i] == 0) ? 1 : m_dur[i];
    q.push_back(exp_t'{busy: 1'b1, idx: i, tone: 1'b0, done: 1'b0});
    for (int c = 0; c < d * TD; c++)
      q.push_back(exp_t'{busy: 1'b1, idx: i, tone: (p != 0) && ((c / p) % 2 == 1), done: 1'b0});
  endfunction

  function automatic void push_end();
    q.push_back(exp_t'{busy: 1'b0, idx: -1, tone: 1'b0, done: 1'b1});
    q.push_back(exp_t'{busy: 1'b0, idx: -1, tone: 1'b0, done: 1'b0});
  endfunction

  function automatic void push_stop(input int k);
    q = q[0:k];
    q.push_back(exp_t'{busy: 1'b0, idx: 0, tone: 1'b0, done: 1'b0});
    q.push_back(exp_t'{busy: 1'b0, idx: 0, tone: 1'b0, done: 1'b0});
  endfunction

  task automatic run_trace(input string tag, input int wr_at, input int stop_at, input int start_at);
    for (int j = 0; j < q.size(); j++) begin
      @(negedge clk);
      wr_en_i = (j == wr_at);
      stop_i  = (j == stop_at);
      start_i = (j == start_at);
      check($sformatf("%s_ctl%0d", tag, j), {busy_o, tone_o, done_o},
            {q[j].busy, q[j].tone, q[j].done});
      if (q[j].idx >= 0)
        check($sformatf("%s_idx%0d", tag, j), note_idx_o, q[j].idx);
    end
    wr_en_i = 1'b0; stop_i = 1'b0; start_i = 1'b0;
    q.delete();
  endtask

  initial begin
    int k;
    int lat;
    for (int i = 0; i < 8; i++) begin m_period[i] = 0; m_dur[i] = 0; end

    #2 rst_i = 1'b1;
    #1 check("reset", {tone_o, busy_o, note_idx_o, done_o}, 6'd0);
    @(negedge clk) rst_i = 1'b0;

    wr(0, 3, 2);
    len_m1_i = 3'd0;
    start_play();
    push_note(0); push_end();
    run_trace("single", -1, -1, -1);

    wr(0, 2, 1); wr(1, 0, 2); wr(2, 5, 1);
    len_m1_i = 3'd2;
`ifdef SOUNDGEN_LOOP_EN
    loop_i = 1'b0;
`else
    loop_i = 1'b1;
`endif
    start_play();
    push_note(0); push_note(1); push_note(2); push_end();
    run_trace("rest", -1, -1, -1);
    loop_i = 1'b0;

    q.push_back(exp_t'{busy: 1'b0, idx: -1, tone: 1'b0, done: 1'b0});
    for (int i = 0; i < 3; i++) q.push_back(exp_t'{busy: 1'b0, idx: 0, tone: 1'b0, done: 1'b0});
    run_trace("stopstart", -1, 0, 0);

    wr(0, 3, 1); wr(1, 2, 1);
    len_m1_i = 3'd1;
    loop_i = 1'b1;
    wr_addr_i = 3'd0; wr_period_i = BW'(7); wr_dur_i = DUR_BW'(1);
    start_play();
`ifdef SOUNDGEN_LOOP_EN
    push_note(0); push_note(1);
    m_period[0] = 7;
    push_note(0);
    k = q.size() + 2;
    push_note(1); push_stop(k);
    run_trace("loop", 2, k, -1);
`else
    push_note(0); push_note(1); push_end();
    run_trace("noloop", 2, -1, -1);
    m_period[0] = 7;
    start_play();
    push_note(0);
    k = q.size() + 2;
    push_note(1); push_stop(k);
    run_trace("newper_stop", -1, k, -1);
`endif
    loop_i = 1'b0;

    wr(0, 4, 3);
    len_m1_i = 3'd0;
    start_play();
    repeat (6) @(negedge clk);
    rst_i = 1'b1;
    #1 check("rst_midplay", {tone_o, busy_o, note_idx_o, done_o}, 6'd0);
    @(negedge clk);
    check("rst_held_done", done_o, 1'b0);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin m_period[i] = 0; m_dur[i] = 0; end
    start_play();
    push_note(0); push_end();
    run_trace("tbl_cleared", -1, -1, -1);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 8; a++) wr(a, $urandom_range(0, 5), $urandom_range(0, 3));
      len_m1_i = 3'($urandom_range(0, 7));
      lat = int'(len_m1_i);
`ifdef SOUNDGEN_LOOP_EN
      loop_i = 1'b0;
`else
      loop_i = 1'($urandom);
`endif
      start_play();
      len_m1_i = 3'($urandom_range(0, 7));
      for (int i = 0; i <= lat; i++) push_note(i);
      push_end();
      run_trace($sformatf("rand%0d", r), -1, -1, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter BW, default 8: width of the note period and half-period counter.
REQ-002 SHALL have parameter DUR_BW, default 8: width of the note duration field, in ticks.
REQ-003 SHALL have parameter TICK_DIV, default 256: clock cycles per duration tick, minimum 2.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start_i, input, 1: start playback at entry 0; honoured only in IDLE.
REQ-007 SHALL have port stop_i, input, 1: abort playback.
REQ-008 SHALL have port len_m1_i, input, 3: sequence length minus 1 (1..8 notes).
REQ-009 SHALL have port loop_i, input, 1: restart at entry 0 after the last note.
REQ-010 SHALL have port wr_en_i, input, 1: note-table write strobe.
REQ-011 SHALL have port wr_addr_i, input, 3: note-table write address.
REQ-012 SHALL have port wr_period_i, input, BW: half-period in clock cycles; 0 means rest.
REQ-013 SHALL have port wr_dur_i, input, DUR_BW: note duration in ticks; 0 is treated as 1.
REQ-014 SHALL have port tone_o, output, 1: square-wave audio output.
REQ-015 SHALL have port busy_o, output, 1: high in LOAD and PLAY.
REQ-016 SHALL have port note_idx_o, output, 3: index of the current entry.
REQ-017 SHALL have port done_o, output, 1: one-cycle pulse at natural sequence end.

Function
REQ-018 SHALL hold an 8-entry table of {period, dur}, written on a clock edge with wr_en_i in any state.
REQ-019 SHALL use FSM states IDLE, LOAD and PLAY.
REQ-020 SHALL go IDLE->LOAD on start_i, latching len_m1_i and setting note_idx_o to 0.
REQ-021 SHALL, in LOAD (exactly 1 cycle), latch table[note_idx] into working period and duration registers, clear the half-period counter, tick prescaler and tone_o, then go to PLAY.
REQ-022 SHALL, in PLAY with period P>0, count cycles 0..P-1 and toggle tone_o when the count reaches P-1, giving a tone frequency of clk/(2P).
REQ-023 SHALL, in PLAY with P=0, hold tone_o at 0.
REQ-024 SHALL, in PLAY, wrap the prescaler at TICK_DIV-1; each wrap decrements the duration count, so a note lasts exactly max(dur,1)*TICK_DIV cycles in PLAY.
REQ-025 SHALL, at note end with note_idx<len_m1, increment note_idx and go to LOAD.
REQ-026 SHALL, at note end on the last note, apply REQ-046 (loop) or else: pulse done_o for 1 cycle, go to IDLE, force tone_o to 0.
REQ-027 SHALL, on stop_i in any state, enter IDLE next cycle with tone_o=0, note_idx_o=0 and no done_o pulse.
REQ-028 SHALL give stop_i priority over start_i, over note end and over loop.
REQ-029 SHALL ignore start_i in LOAD and PLAY.
REQ-030 SHALL leave the playing note unaffected by a table write to its entry; the new value takes effect at that entry's next LOAD.
REQ-031 SHALL apply a mid-sequence change of len_m1_i only at the next start.
REQ-032 SHALL sample loop_i at the last-note end only.
REQ-033 SHALL set busy_o=0 in IDLE and the cycle done_o is high.

Reset
REQ-034 SHALL, on rst_i, immediately and asynchronously enter IDLE.
REQ-035 SHALL reset tone_o=0, busy_o=0, note_idx_o=0, done_o=0, all counters=0 and the table to all zeros.
REQ-036 SHALL, when rst_i asserts mid-PLAY, abort the note without a done_o pulse.

Configuration
REQ-046 SHALL compile looping in only when SOUNDGEN_LOOP_EN is defined: with it, a last-note end with loop_i=1 sets note_idx to 0, goes to LOAD and produces no done_o; without it, loop_i is ignored (port kept) and every sequence ends per REQ-026.

Verification (TICK_DIV=4)
REQ-047 SHALL verify reset: assert rst_i mid-PLAY -> tone_o, busy_o, note_idx_o and done_o are all 0 before the next clock edge.
REQ-048 SHALL verify a single note: entry0 = {3,2}, len_m1_i=0, start -> busy_o high next cycle, 1 LOAD cycle, tone_o toggles every 3 cycles for 8 PLAY cycles, then done_o=1 for 1 cycle and busy_o=0.
REQ-049 SHALL verify a rest: entries {2,1},{0,2},{5,1}, len_m1_i=2 -> note_idx_o steps 0,1,2, tone_o stays 0 for 8 PLAY cycles at idx 1, single done_o pulse.
REQ-050 SHALL verify looping: SOUNDGEN_LOOP_EN defined, loop_i=1, len_m1_i=1 -> idx goes 0,1,0,1 with no done_o; stop_i during idx 1 -> IDLE next cycle, tone_o=0, no done_o.
REQ-051 SHALL verify looping compiled out: macro undefined, loop_i=1 -> done_o after the last note, then IDLE.
REQ-052 SHALL verify simultaneous events: stop_i and start_i together in IDLE -> stays IDLE; write entry 0 period=7 while entry 0 plays with period 3 -> current half-period stays 3, the next loop pass uses 7.
